// File: rtl/vli_dc_pred_decoder_pkg.sv
// Shared defaults and item types for the streaming VLI decode / DC prediction block.
package vli_dc_pred_decoder_pkg;

  localparam int VLI_MAX_SIZE = 11;
  localparam int VLI_COEFF_W  = 12;
  localparam int VLI_NUM_COMP = 3;
  localparam int VLI_SIZE_W   = 4;

  typedef logic signed [VLI_COEFF_W-1:0] coeff_t;

  typedef struct packed {
    logic [VLI_SIZE_W-1:0]   size;
    logic [VLI_MAX_SIZE-1:0] symbol;
    logic                    is_dc;
    logic [1:0]              comp;
  } vli_item_t;

  function automatic int comp_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vli_dc_pred_decoder_extend.sv
// Combinational JPEG VLI mask + sign-extension of a (size, magnitude-bits) pair.
module vli_dc_pred_decoder_extend #(
  parameter int MAX_SIZE = 11,
  parameter int COEFF_W  = 12,
  parameter int SIZE_W   = 4
) (
  input  logic [SIZE_W-1:0]   i_size,
  input  logic [MAX_SIZE-1:0] i_symbol,
  output logic [COEFF_W-1:0]  o_value
);

  localparam logic signed [COEFF_W-1:0] ONE = 1;

  logic [MAX_SIZE-1:0]       w_masked;
  logic                      w_msb;
  logic signed [COEFF_W-1:0] w_mag;
  logic signed [COEFF_W-1:0] w_off;

  // Bits at or above the size are dropped; the top surviving bit selects the sign.
  always_comb begin
    w_masked = '0;
    w_msb    = 1'b0;
    for (int i = 0; i < MAX_SIZE; i++) begin
      if (i < int'(i_size))
        w_masked[i] = i_symbol[i];
      if (i + 1 == int'(i_size))
        w_msb = i_symbol[i];
    end
  end

  assign w_mag   = COEFF_W'(w_masked);
  assign w_off   = (ONE <<< i_size) - ONE;
  assign o_value = (i_size == '0) ? '0 : (w_msb ? w_mag : w_mag - w_off);

endmodule

// File: rtl/vli_dc_pred_decoder.sv
// Two-stage streaming VLI decoder: stage 1 sign-extends, stage 2 applies the
// per-component DC predictor. Valid/ready on both sides, one item per cycle.
module vli_dc_pred_decoder
  import vli_dc_pred_decoder_pkg::*;
#(
  parameter int MAX_SIZE = VLI_MAX_SIZE,
  parameter int COEFF_W  = VLI_COEFF_W,
  parameter int NUM_COMP = VLI_NUM_COMP,
  parameter int COMP_W   = comp_width(NUM_COMP)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VLI_SIZE_W-1:0] in_size,
  input  logic [MAX_SIZE-1:0]   in_symbol,
  input  logic                  in_is_dc,
  input  logic [COMP_W-1:0]     in_comp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COEFF_W-1:0]    out_value,
  output logic                  out_is_dc,
  output logic [COMP_W-1:0]     out_comp,
  output logic                  err
);

  localparam logic [VLI_SIZE_W-1:0] MAX_SIZE_L = VLI_SIZE_W'(MAX_SIZE);
  localparam logic [COMP_W:0]       NUM_COMP_L = (COMP_W+1)'(NUM_COMP);

  logic                      r_vld_p1, r_is_dc_p1, r_ill_p1;
  logic [COMP_W-1:0]         r_comp_p1;
  logic signed [COEFF_W-1:0] r_diff_p1;
  logic                      r_vld_p2, r_is_dc_p2;
  logic [COMP_W-1:0]         r_comp_p2;
  logic signed [COEFF_W-1:0] r_val_p2;
  logic signed [COEFF_W-1:0] r_pred [NUM_COMP];
  logic                      r_err;

  logic [COEFF_W-1:0]        w_ext;
  logic                      w_illegal, w_adv_p1, w_accept, w_move_p1, w_dc_upd;
  logic signed [COEFF_W-1:0] w_base_p2, w_sum_p2;

  vli_dc_pred_decoder_extend #(
    .MAX_SIZE (MAX_SIZE),
    .COEFF_W  (COEFF_W),
    .SIZE_W   (VLI_SIZE_W)
  ) u_extend (
    .i_size   (in_size),
    .i_symbol (in_symbol),
    .o_value  (w_ext)
  );

  assign w_illegal = (in_size > MAX_SIZE_L) || ({1'b0, in_comp} >= NUM_COMP_L);
  assign w_adv_p1  = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_adv_p1;
  assign w_accept  = in_valid && in_ready;
  assign w_move_p1 = r_vld_p1 && w_adv_p1;

  // restart takes effect before the predictor read of an item moving into stage 2.
  assign w_base_p2 = restart ? '0 : r_pred[r_comp_p1];
  assign w_sum_p2  = w_base_p2 + r_diff_p1;
  assign w_dc_upd  = w_move_p1 && r_is_dc_p1 && !r_ill_p1;

  // Stage 1: registered VLI decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1   <= 1'b0;
      r_is_dc_p1 <= 1'b0;
      r_ill_p1   <= 1'b0;
      r_comp_p1  <= '0;
      r_diff_p1  <= '0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_is_dc_p1 <= in_is_dc;
        r_ill_p1   <= w_illegal;
        r_comp_p1  <= in_comp;
        r_diff_p1  <= w_illegal ? '0 : signed'(w_ext);
      end
    end
  end

  // Stage 2: DC prediction and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p2   <= 1'b0;
      r_is_dc_p2 <= 1'b0;
      r_comp_p2  <= '0;
      r_val_p2   <= '0;
    end else if (w_move_p1) begin
      r_vld_p2   <= 1'b1;
      r_is_dc_p2 <= r_is_dc_p1;
      r_comp_p2  <= r_comp_p1;
      r_val_p2   <= w_dc_upd ? w_sum_p2 : r_diff_p1;
    end else if (out_ready) begin
      r_vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_COMP; c++)
        r_pred[c] <= '0;
    end else begin
      if (restart)
        for (int c = 0; c < NUM_COMP; c++)
          r_pred[c] <= '0;
      if (w_dc_upd)
        r_pred[r_comp_p1] <= w_sum_p2;
    end
  end

  // A fresh illegal item on the restart edge still leaves err flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      if (restart)
        r_err <= 1'b0;
      if (w_accept && w_illegal)
        r_err <= 1'b1;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_value = r_val_p2;
  assign out_is_dc = r_is_dc_p2;
  assign out_comp  = r_comp_p2;
  assign err       = r_err;

endmodule

// File: tb/tb_vli_dc_pred_decoder.sv
// Directed bench for vli_dc_pred_decoder with a scoreboard of hand-derived expected items.
module tb_vli_dc_pred_decoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, in_ready, in_is_dc;
  logic        out_valid, out_ready, out_is_dc, err;
  logic [3:0]  in_size;
  logic [10:0] in_symbol;
  logic [1:0]  in_comp, out_comp;
  logic [11:0] out_value;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [14:0] sb [$];
  logic [14:0] exp_item;

  always #5 clk = ~clk;

  vli_dc_pred_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_size   (in_size),
    .in_symbol (in_symbol),
    .in_is_dc  (in_is_dc),
    .in_comp   (in_comp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_is_dc (out_is_dc),
    .out_comp  (out_comp),
    .err       (err)
  );

  function automatic logic [11:0] c12(input int v);
    return v[11:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one item, wait (bounded) for acceptance, queue its expected output.
  task automatic send(input logic [3:0] sz, input logic [10:0] sym, input logic dc,
                      input logic [1:0] cp, input int exp);
    int k = 0;
    in_valid  = 1'b1;
    in_size   = sz;
    in_symbol = sym;
    in_is_dc  = dc;
    in_comp   = cp;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("accept", in_ready, 1);
    sb.push_back({c12(exp), dc, cp});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      k++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", out_valid, 0);
      end else begin
        exp_item = sb.pop_front();
        chk("out_item", {17'b0, out_value, out_is_dc, out_comp}, {17'b0, exp_item});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; in_size = '0;
    in_symbol = '0; in_is_dc = 1'b0; in_comp = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_is_dc", out_is_dc, 0);
    chk("rst_out_comp", out_comp, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    // AC decode and two-cycle latency
    send(4'd3, 11'b111, 1'b0, 2'd0, 7);
    chk("lat_cycle1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", out_valid, 1);
    chk("lat_cycle2_value", out_value, c12(7));
    send(4'd0, 11'h7ff, 1'b0, 2'd0, 0);
    drain();

    // DC prediction on comp0, back to back, then AC leaves predictor alone
    send(4'd1, 11'b1, 1'b1, 2'd0, 1);
    send(4'd2, 11'b01, 1'b1, 2'd0, -1);
    send(4'd1, 11'b0, 1'b0, 2'd0, -1);
    drain();

    // comp1 does not disturb comp0 (pred0 is -1)
    send(4'd11, 11'b0, 1'b1, 2'd1, -2047);
    send(4'd1, 11'b1, 1'b1, 2'd0, 0);
    drain();

    // bits above size are masked
    send(4'd3, 11'b11000, 1'b0, 2'd2, -7);
    drain();

    // downstream stall with four AC items
    out_ready = 1'b0;
    send(4'd1, 11'b1, 1'b0, 2'd0, 1);
    send(4'd2, 11'b10, 1'b0, 2'd0, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_first_value", out_value, c12(1));
    fork
      begin
        send(4'd2, 11'b11, 1'b0, 2'd0, 3);
        send(4'd3, 11'b100, 1'b0, 2'd0, 4);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_valid_stable", out_valid, 1);
        chk("stall_value_stable", out_value, c12(1));
        chk("stall_in_ready_held", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();

    // restart clears predictors (pred1 was -2047)
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    send(4'd0, 11'b0, 1'b1, 2'd2, 0);
    send(4'd1, 11'b1, 1'b1, 2'd1, 1);
    send(4'd1, 11'b1, 1'b1, 2'd0, 1);
    drain();
    chk("err_before_illegal", err, 0);

    // illegal size and illegal comp pass through as 0, predictors untouched
    send(4'd12, 11'h7ff, 1'b0, 2'd0, 0);
    chk("err_on_size", err, 1);
    send(4'd1, 11'b1, 1'b1, 2'd3, 0);
    send(4'd1, 11'b1, 1'b1, 2'd0, 2);
    drain();
    chk("err_sticky", err, 1);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    chk("err_cleared", err, 0);

    // reset with two items in flight
    out_ready = 1'b0;
    send(4'd1, 11'b1, 1'b0, 2'd0, 1);
    send(4'd1, 11'b0, 1'b0, 2'd1, -1);
    chk("flight_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_value", out_value, 0);
    chk("async_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_late_output", out_valid, 0);
    send(4'd1, 11'b1, 1'b1, 2'd0, 1);
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
